// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control,
// PC and retired-instruction tracking, stop-at-boundary and sticky ack-timeout fault.
module cpu_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        mem_load,
    input  logic        mem_store,
    input  logic        jump_en,
    input  logic        reg_write_enable,
    input  logic [31:0] jump_addr,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        ir_load,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        fault,
    output logic [31:0] instr_count
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   icnt_q, icnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          complete;
    logic          jump_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            icnt_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            icnt_q  <= icnt_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Request/strobe outputs decode the registered state so reset drops them at once.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        icnt_d    = icnt_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        complete  = 1'b0;
        jump_done = 1'b0;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        fault     = 1'b0;

        if (stop && state_q != S_IDLE && state_q != S_FAULT) begin
            pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (mem_load || mem_store) begin
                    state_d = S_MEM;
                    cnt_d   = '0;
                end else if (jump_en) begin
                    complete  = 1'b1;
                    jump_done = 1'b1;
                end else if (reg_write_enable) begin
                    state_d = S_WB;
                end else begin
                    complete = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_store;
                if (dmem_ack) begin
                    if (mem_load) begin
                        state_d = S_WB;
                    end else begin
                        complete = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = S_FAULT;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                complete = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Instruction boundary: advance PC, retire, and honour a pending stop.
        if (complete) begin
            pc_d    = jump_done ? (pc_q + 32'd4 + (jump_addr << 2)) : (pc_q + 32'd4);
            icnt_d  = icnt_q + 32'd1;
            state_d = pend_q ? S_IDLE : S_FETCH;
            cnt_d   = '0;
        end

        if (state_d == S_IDLE) begin
            pend_d = 1'b0;
        end
    end

    assign pc          = pc_q;
    assign instr_count = icnt_q;
    assign state       = state_q;

endmodule
